out_port_alloc: RTL and testbench

Per-output-port allocation and link controller for the mesh router; one instance per output port, opposite the crossbar switch. It answers the switch's output-port requests with one-hot acknowledgements and locks the port to the winning input until the packet's tail flit. It buffers the switched flits in a small FIFO and drives them onto the outgoing link under credit-based flow control. It publishes the port's FREE/BUSY status that the switch uses to qualify its requests.

---
 rtl/router_pkg.sv | 49 ++++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/out_port_alloc.sv | 140 ++++++++++++++
 tb/tb_out_port_alloc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types: flit format, switch-to-output bus, port status and the
// output-port allocator state encoding.
package router_pkg;

  localparam int NUM_OF_PORTS   = 5;
  localparam int FLIT_DATA_W    = 16;
  localparam int OBUF_DEPTH_DEF = 4;
  localparam int CREDITS_DEF    = 4;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } flit_type_t;

  typedef struct packed {
    logic                   valid;
    flit_type_t             ftype;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

  typedef struct packed {
    flit_t flit;
  } router_pipeline_bus_t;

  typedef enum logic {
    PORT_FREE = 1'b0,
    PORT_BUSY = 1'b1
  } port_status_t;

  typedef struct packed {
    port_status_t port_status;
  } OUT_PORT_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACTIVE = 2'd2
  } alloc_state_t;

  function automatic flit_t invalid_flit();
    flit_t f;
    f.valid = 1'b0;
    f.ftype = HEAD_FLIT;
    f.data  = '0;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant for the first request at or after the
// priority pointer; the pointer moves past the winner only when update_i is set.
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         update_i,
  output logic [N-1:0] gnt_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_i[wrap_idx(ptr_q, k)]) begin
        gnt_o[wrap_idx(ptr_q, k)] = 1'b1;
        found                     = 1'b1;
        ptr_d                     = wrap_idx(ptr_q, k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr_q <= '0;
    else if (update_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/out_port_alloc.sv
// Output-port allocator and link driver: grants the port to one input per
// packet, buffers switched flits and sends them under credit flow control.
//
//   state  | meaning
//   IDLE   | port unowned; arbitrate requests when the FIFO has room
//   GRANT  | one-cycle ack to the recorded owner
//   ACTIVE | owner streams flits until its tail is buffered
module out_port_alloc
  import router_pkg::*;
#(
  parameter int PORT_ID      = 0,
  parameter int NUM_OF_PORTS = router_pkg::NUM_OF_PORTS,
  parameter int OBUF_DEPTH   = OBUF_DEPTH_DEF,
  parameter int CREDITS      = CREDITS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_OF_PORTS-1:0] i_outport_req,
  output logic [NUM_OF_PORTS-1:0] o_outport_ack,
  input  router_pipeline_bus_t    i_s2o,
  output OUT_PORT_t               o_status,
  output flit_t                   o_link_flit,
  output logic                    o_link_valid,
  input  logic                    i_credit_ret,
  output logic                    o_overflow
);

  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int OW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;

  if (PORT_ID < 0 || PORT_ID >= NUM_OF_PORTS) begin : g_bad_port_id
    $error("out_port_alloc: PORT_ID out of range");
  end

  alloc_state_t      state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d, gnt_idx;
  logic [NUM_OF_PORTS-1:0] gnt;
  logic              arb_update;

  flit_t             fifo_q [OBUF_DEPTH];
  logic [PW:0]       wr_ptr_q, rd_ptr_q, count;
  logic              full, empty, wr_en, pop;

  logic [CW-1:0]     credits_q, credits_d;
  flit_t             link_flit_q;
  logic              link_valid_q, overflow_q;

  assign count      = wr_ptr_q - rd_ptr_q;
  assign full       = (count == (PW+1)'(OBUF_DEPTH));
  assign empty      = (count == '0);
  assign arb_update = (state_q == IDLE) && (|i_outport_req) && !full;
  assign wr_en      = (state_q != IDLE) && i_s2o.flit.valid && !full;
  assign pop        = !empty && (credits_q != '0);

  rr_arbiter #(.N(NUM_OF_PORTS)) u_rr_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (i_outport_req),
    .update_i (arb_update),
    .gnt_o    (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_OF_PORTS; k++) begin
      if (gnt[k]) gnt_idx = OW'(k);
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    o_outport_ack = '0;
    case (state_q)
      IDLE: begin
        if (arb_update) begin
          state_d = GRANT;
          owner_d = gnt_idx;
        end
      end
      GRANT: begin
        o_outport_ack = NUM_OF_PORTS'(1) << owner_q;
        state_d       = ACTIVE;
      end
      ACTIVE: begin
        if (wr_en && i_s2o.flit.ftype == TAIL_FLIT) begin
          state_d = IDLE;
          owner_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pop and return together leave the count untouched; returns saturate.
  always_comb begin
    credits_d = credits_q;
    if (pop && !i_credit_ret)
      credits_d = credits_q - CW'(1);
    else if (!pop && i_credit_ret && credits_q != CW'(CREDITS))
      credits_d = credits_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      credits_q    <= CW'(CREDITS);
      link_flit_q  <= invalid_flit();
      link_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      credits_q    <= credits_d;
      link_valid_q <= pop;
      link_flit_q  <= pop ? fifo_q[rd_ptr_q[PW-1:0]] : invalid_flit();
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if ((state_q != IDLE) && i_s2o.flit.valid && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q[PW-1:0]] <= i_s2o.flit;
  end

  always_comb begin
    o_status             = '0;
    o_status.port_status = (state_q == IDLE && !full) ? PORT_FREE : PORT_BUSY;
  end

  assign o_link_flit  = link_flit_q;
  assign o_link_valid = link_valid_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_out_port_alloc.sv
// Bench for out_port_alloc: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based reference model.
module tb_out_port_alloc;
  import router_pkg::*;

  localparam int N = NUM_OF_PORTS;
  localparam int D = 4;
  localparam int C = 4;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic [N-1:0]         i_outport_req = '0;
  logic [N-1:0]         o_outport_ack;
  router_pipeline_bus_t i_s2o;
  OUT_PORT_t            o_status;
  flit_t                o_link_flit;
  logic                 o_link_valid;
  logic                 i_credit_ret = 1'b0;
  logic                 o_overflow;

  out_port_alloc #(.PORT_ID(0), .NUM_OF_PORTS(N), .OBUF_DEPTH(D), .CREDITS(C)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_outport_req (i_outport_req),
    .o_outport_ack (o_outport_ack),
    .i_s2o         (i_s2o),
    .o_status      (o_status),
    .o_link_flit   (o_link_flit),
    .o_link_valid  (o_link_valid),
    .i_credit_ret  (i_credit_ret),
    .o_overflow    (o_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_link   = 0;
  int ack_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, credits as a plain integer.
  flit_t m_q[$];
  int    m_credits, m_owner, m_ptr;
  bit    m_granting, m_owned, m_lv, m_ovf;
  flit_t m_lf;

  function automatic void model_reset();
    m_q.delete();
    m_credits  = C;
    m_owner    = 0;
    m_ptr      = 0;
    m_granting = 0;
    m_owned    = 0;
    m_lv       = 0;
    m_ovf      = 0;
    m_lf       = invalid_flit();
  endfunction

  function automatic void model_step(input logic [N-1:0] req, input flit_t f, input bit cret);
    bit    full, pop, wr, picked;
    flit_t popped;
    full   = (m_q.size() == D);
    pop    = (m_q.size() > 0) && (m_credits > 0);
    wr     = (m_granting || m_owned) && f.valid;
    popped = invalid_flit();
    if (pop) popped = m_q.pop_front();
    if (wr) begin
      if (full) m_ovf = 1;
      else      m_q.push_back(f);
    end
    m_lv      = pop;
    m_lf      = popped;
    m_credits = m_credits - (pop ? 1 : 0) + (cret ? 1 : 0);
    if (m_credits > C) m_credits = C;
    if (m_granting) begin
      m_granting = 0;
      m_owned    = 1;
    end else if (m_owned) begin
      if (wr && !full && f.ftype == TAIL_FLIT) m_owned = 0;
    end else if (req != 0 && !full) begin
      picked = 0;
      for (int k = 0; k < N; k++) begin
        if (!picked && req[(m_ptr + k) % N]) begin
          picked     = 1;
          m_owner    = (m_ptr + k) % N;
          m_ptr      = (m_owner + 1) % N;
          m_granting = 1;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    check("ack", 64'(o_outport_ack), 64'(m_granting ? (1 << m_owner) : 0));
    check("status", 64'(o_status.port_status),
          64'((!m_granting && !m_owned && m_q.size() < D) ? PORT_FREE : PORT_BUSY));
    check("link_valid", 64'(o_link_valid), 64'(m_lv));
    check("link_flit", 64'(o_link_flit), 64'(m_lf));
    check("overflow", 64'(o_overflow), 64'(m_ovf));
    if (o_link_valid) n_link++;
    for (int k = 0; k < N; k++) if (o_outport_ack[k]) ack_log.push_back(k);
  endtask

  task automatic step(input logic [N-1:0] req, input flit_t f, input bit cret);
    @(negedge clk);
    check_outputs();
    i_outport_req = req;
    i_s2o.flit    = f;
    i_credit_ret  = cret;
    model_step(req, f, cret);
    @(posedge clk);
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    i_outport_req = '0;
    i_s2o.flit    = invalid_flit();
    i_credit_ret  = 1'b0;
    #1;
    check("rst_ack", 64'(o_outport_ack), 64'(0));
    check("rst_link_valid", 64'(o_link_valid), 64'(0));
    check("rst_link_flit", 64'(o_link_flit), 64'(invalid_flit()));
    check("rst_overflow", 64'(o_overflow), 64'(0));
    check("rst_status", 64'(o_status.port_status), 64'(PORT_FREE));
    model_reset();
    n_link = 0;
    ack_log.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  function automatic flit_t mk(input flit_type_t t, input int d);
    flit_t f;
    f.valid = 1'b1;
    f.ftype = t;
    f.data  = FLIT_DATA_W'(d);
    return f;
  endfunction

  task automatic idle(input int n, input bit cret);
    for (int i = 0; i < n; i++) step('0, invalid_flit(), cret);
  endtask

  task automatic send_pkt(input logic [N-1:0] req, input int len, input int base, input bit cret);
    for (int i = 0; i < len; i++)
      step(req, mk((i == 0) ? HEAD_FLIT : (i == len - 1) ? TAIL_FLIT : BODY_FLIT, base + i), cret);
  endtask

  int pct[3];
  int p;
  flit_t rf;
  logic [N-1:0] rreq;

  initial begin
    i_s2o.flit = invalid_flit();
    pct[0] = 20; pct[1] = 55; pct[2] = 90;
    #2;
    apply_reset();

    // single request from input 2
    step(5'b00100, invalid_flit(), 1'b0);
    step('0, invalid_flit(), 1'b0);
    send_pkt('0, 3, 16'h100, 1'b0);
    idle(5, 1'b0);
    check("single_link_count", 64'(n_link), 64'(3));
    check("single_ack_count", 64'(ack_log.size()), 64'(1));
    if (ack_log.size() == 1) check("single_ack_idx", 64'(ack_log[0]), 64'(2));
    check("single_back_idle", 64'(o_status.port_status), 64'(PORT_FREE));

    // contention 10011 over three packets
    apply_reset();
    for (int pk = 0; pk < 3; pk++) begin
      step(5'b10011, invalid_flit(), 1'b1);
      step(5'b10011, invalid_flit(), 1'b1);
      send_pkt(5'b10011, 3, 16'h200 + 16 * pk, 1'b1);
    end
    idle(5, 1'b1);
    check("contend_ack_count", 64'(ack_log.size()), 64'(3));
    if (ack_log.size() == 3) begin
      check("contend_grant0", 64'(ack_log[0]), 64'(0));
      check("contend_grant1", 64'(ack_log[1]), 64'(1));
      check("contend_grant2", 64'(ack_log[2]), 64'(4));
    end

    // credit stall with a 6-flit packet
    apply_reset();
    step(5'b00001, invalid_flit(), 1'b0);
    step('0, invalid_flit(), 1'b0);
    send_pkt('0, 6, 16'h300, 1'b0);
    idle(8, 1'b0);
    check("stall_link_count", 64'(n_link), 64'(4));
    step('0, invalid_flit(), 1'b1);
    idle(6, 1'b0);
    check("stall_one_more", 64'(n_link), 64'(5));

    // pop and return together while credits sit at 1
    apply_reset();
    step(5'b01000, invalid_flit(), 1'b0);
    step('0, invalid_flit(), 1'b0);
    for (int i = 0; i < 7; i++)
      step('0, mk((i == 0) ? HEAD_FLIT : (i == 6) ? TAIL_FLIT : BODY_FLIT, 16'h400 + i), (i >= 4));
    step('0, invalid_flit(), 1'b1);
    idle(4, 1'b0);
    check("popret_link_count", 64'(n_link), 64'(7));

    // overflow with credits exhausted
    apply_reset();
    step(5'b00010, invalid_flit(), 1'b0);
    step('0, invalid_flit(), 1'b0);
    send_pkt('0, 9, 16'h500, 1'b0);
    idle(6, 1'b0);
    check("ovf_flag", 64'(o_overflow), 64'(1));
    check("ovf_status", 64'(o_status.port_status), 64'(PORT_BUSY));
    check("ovf_link_count", 64'(n_link), 64'(4));

    // reset in the middle of a packet
    apply_reset();
    step(5'b00100, invalid_flit(), 1'b1);
    step('0, invalid_flit(), 1'b1);
    step('0, mk(HEAD_FLIT, 16'h600), 1'b1);
    step('0, mk(BODY_FLIT, 16'h601), 1'b1);
    #2;
    apply_reset();
    step(5'b10000, invalid_flit(), 1'b0);
    step('0, invalid_flit(), 1'b0);
    idle(2, 1'b0);
    check("post_rst_ack_count", 64'(ack_log.size()), 64'(1));
    if (ack_log.size() == 1) check("post_rst_ack_idx", 64'(ack_log[0]), 64'(4));
    send_pkt('0, 5, 16'h700, 1'b0);
    idle(8, 1'b0);
    check("post_rst_credits", 64'(n_link), 64'(4));

    // random traffic
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p    = pct[(cyc / 250) % 3];
      rreq = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
      rf   = invalid_flit();
      if ($urandom_range(0, 99) < 60) begin
        rf.valid = 1'b1;
        rf.ftype = ($urandom_range(0, 3) == 0) ? TAIL_FLIT : flit_type_t'($urandom_range(0, 1));
        rf.data  = FLIT_DATA_W'($urandom);
      end
      step(rreq, rf, ($urandom_range(0, 99) < p));
    end
    idle(3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
